// File: rtl/axi4_slave_mem.sv
// axi4_slave_mem: AXI4-Full slave endpoint backed by an internal word-addressed memory.
// Independent write and read FSMs; FIXED and INCR bursts, byte-strobe writes, one read
// beat per cycle. Define AXI4_SLAVE_WRAP_EN to support WRAP bursts of 2/4/8/16 beats;
// without it WRAP is answered with SLVERR.
module axi4_slave_mem #(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 24,
    parameter int unsigned MEM_WORDS_LOG2     = 10
) (
    input  logic                              s_axi_aclk,
    input  logic                              s_axi_aresetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s_axi_awaddr,
    input  logic [7:0]                        s_axi_awlen,
    input  logic [2:0]                        s_axi_awsize,
    input  logic [1:0]                        s_axi_awburst,
    input  logic                              s_axi_awvalid,
    output logic                              s_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     s_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s_axi_wstrb,
    input  logic                              s_axi_wlast,
    input  logic                              s_axi_wvalid,
    output logic                              s_axi_wready,
    output logic [1:0]                        s_axi_bresp,
    output logic                              s_axi_bvalid,
    input  logic                              s_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s_axi_araddr,
    input  logic [7:0]                        s_axi_arlen,
    input  logic [2:0]                        s_axi_arsize,
    input  logic [1:0]                        s_axi_arburst,
    input  logic                              s_axi_arvalid,
    output logic                              s_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     s_axi_rdata,
    output logic [1:0]                        s_axi_rresp,
    output logic                              s_axi_rlast,
    output logic                              s_axi_rvalid,
    input  logic                              s_axi_rready
);

    localparam int unsigned StrbW = C_S_AXI_DATA_WIDTH / 8;
    localparam int unsigned Words = 1 << MEM_WORDS_LOG2;
`ifdef AXI4_SLAVE_WRAP_EN
    localparam bit WrapEn = 1'b1;
`else
    localparam bit WrapEn = 1'b0;
`endif
    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlvErr = 2'b10;
    localparam logic [1:0] BurstFixed = 2'b00;
    localparam logic [1:0] BurstIncr  = 2'b01;
    localparam logic [1:0] BurstWrap  = 2'b10;

    typedef logic [MEM_WORDS_LOG2-1:0]     idx_t;
    typedef logic [C_S_AXI_DATA_WIDTH-1:0] word_t;

    typedef enum logic [1:0] {WRst, WIdle, WData, WResp} w_state_e;
    typedef enum logic [1:0] {RRst, RIdle, RData} r_state_e;

    // Only 4-byte beats; WRAP needs a power-of-two length of 2..16 beats.
    function automatic logic burst_legal(logic [2:0] size, logic [1:0] burst, logic [7:0] len);
        logic ok;
        ok = 1'b0;
        case (burst)
            BurstFixed, BurstIncr: ok = 1'b1;
            BurstWrap: ok = WrapEn && ((len == 8'd1) || (len == 8'd3) ||
                                       (len == 8'd7) || (len == 8'd15));
            default:   ok = 1'b0;
        endcase
        return ok && (size == 3'b010);
    endfunction

    // WRAP keeps the upper index bits and rolls the low bits inside the len+1 window.
    function automatic idx_t next_idx(idx_t idx, logic [1:0] burst, logic [7:0] len);
        idx_t inc;
        idx_t mask;
        inc  = idx + idx_t'(1);
        mask = idx_t'(len);
        case (burst)
            BurstFixed: return idx;
            BurstWrap:  return (idx & ~mask) | (inc & mask);
            default:    return inc;
        endcase
    endfunction

    word_t    mem_q [Words];

    w_state_e w_state_q, w_state_d;
    idx_t     w_idx_q, w_idx_d;
    logic [7:0] w_len_q, w_len_d, w_cnt_q, w_cnt_d;
    logic [1:0] w_burst_q, w_burst_d, bresp_q, bresp_d;
    logic     w_nowr_q, w_nowr_d, w_err_q, w_err_d;
    logic     mem_we, w_last_beat;

    r_state_e r_state_q, r_state_d;
    idx_t     r_idx_q, r_idx_d, r_nidx, ar_idx;
    logic [7:0] r_len_q, r_len_d, r_cnt_q, r_cnt_d;
    logic [1:0] r_burst_q, r_burst_d, rresp_q, rresp_d;
    logic     r_err_q, r_err_d, rlast_q, rlast_d, ar_legal;
    word_t    rdata_q, rdata_d;

    // Address bits outside the word index are intentionally ignored.
    logic unused_addr;
    assign unused_addr = ^{s_axi_awaddr, s_axi_araddr};

    assign w_last_beat = (w_cnt_q == w_len_q);
    assign ar_idx      = s_axi_araddr[MEM_WORDS_LOG2+1:2];
    assign ar_legal    = burst_legal(s_axi_arsize, s_axi_arburst, s_axi_arlen);
    assign r_nidx      = next_idx(r_idx_q, r_burst_q, r_len_q);

    // Write FSM: accept AW, consume all W beats, then hold B until bready.
    always_comb begin
        w_state_d = w_state_q;
        w_idx_d   = w_idx_q;
        w_len_d   = w_len_q;
        w_burst_d = w_burst_q;
        w_cnt_d   = w_cnt_q;
        w_nowr_d  = w_nowr_q;
        w_err_d   = w_err_q;
        bresp_d   = bresp_q;
        mem_we    = 1'b0;
        case (w_state_q)
            WRst: w_state_d = WIdle;
            WIdle: begin
                if (s_axi_awvalid) begin
                    w_state_d = WData;
                    w_idx_d   = s_axi_awaddr[MEM_WORDS_LOG2+1:2];
                    w_len_d   = s_axi_awlen;
                    w_burst_d = s_axi_awburst;
                    w_cnt_d   = 8'd0;
                    w_nowr_d  = !burst_legal(s_axi_awsize, s_axi_awburst, s_axi_awlen);
                    w_err_d   = 1'b0;
                end
            end
            WData: begin
                if (s_axi_wvalid) begin
                    // A wlast mismatch flags the response but the beat is still stored.
                    mem_we = !w_nowr_q;
                    if (w_last_beat) begin
                        w_state_d = WResp;
                        bresp_d   = (w_nowr_q || w_err_q || !s_axi_wlast) ? RespSlvErr : RespOkay;
                    end else begin
                        w_cnt_d = w_cnt_q + 8'd1;
                        w_idx_d = next_idx(w_idx_q, w_burst_q, w_len_q);
                        if (s_axi_wlast) begin
                            w_err_d = 1'b1;
                        end
                    end
                end
            end
            WResp: begin
                if (s_axi_bready) begin
                    w_state_d = WIdle;
                end
            end
            default: w_state_d = WRst;
        endcase
    end

    // Read FSM: registered rdata, next word loaded on each non-final R handshake.
    always_comb begin
        r_state_d = r_state_q;
        r_idx_d   = r_idx_q;
        r_len_d   = r_len_q;
        r_burst_d = r_burst_q;
        r_cnt_d   = r_cnt_q;
        r_err_d   = r_err_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        rlast_d   = rlast_q;
        case (r_state_q)
            RRst: r_state_d = RIdle;
            RIdle: begin
                if (s_axi_arvalid) begin
                    r_state_d = RData;
                    r_idx_d   = ar_idx;
                    r_len_d   = s_axi_arlen;
                    r_burst_d = s_axi_arburst;
                    r_cnt_d   = 8'd0;
                    r_err_d   = !ar_legal;
                    rdata_d   = ar_legal ? mem_q[ar_idx] : '0;
                    rresp_d   = ar_legal ? RespOkay : RespSlvErr;
                    rlast_d   = (s_axi_arlen == 8'd0);
                end
            end
            RData: begin
                if (s_axi_rready) begin
                    if (rlast_q) begin
                        r_state_d = RIdle;
                        rlast_d   = 1'b0;
                    end else begin
                        r_idx_d = r_nidx;
                        r_cnt_d = r_cnt_q + 8'd1;
                        rdata_d = r_err_q ? '0 : mem_q[r_nidx];
                        rlast_d = ((r_cnt_q + 8'd1) == r_len_q);
                    end
                end
            end
            default: r_state_d = RRst;
        endcase
    end

    // State registers for both channels; reset aborts any burst in flight.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            w_state_q <= WRst;
            w_idx_q   <= '0;
            w_len_q   <= 8'd0;
            w_burst_q <= 2'b00;
            w_cnt_q   <= 8'd0;
            w_nowr_q  <= 1'b0;
            w_err_q   <= 1'b0;
            bresp_q   <= RespOkay;
            r_state_q <= RRst;
            r_idx_q   <= '0;
            r_len_q   <= 8'd0;
            r_burst_q <= 2'b00;
            r_cnt_q   <= 8'd0;
            r_err_q   <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RespOkay;
            rlast_q   <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            w_idx_q   <= w_idx_d;
            w_len_q   <= w_len_d;
            w_burst_q <= w_burst_d;
            w_cnt_q   <= w_cnt_d;
            w_nowr_q  <= w_nowr_d;
            w_err_q   <= w_err_d;
            bresp_q   <= bresp_d;
            r_state_q <= r_state_d;
            r_idx_q   <= r_idx_d;
            r_len_q   <= r_len_d;
            r_burst_q <= r_burst_d;
            r_cnt_q   <= r_cnt_d;
            r_err_q   <= r_err_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            rlast_q   <= rlast_d;
        end
    end

    // Memory array is not reset; a same-edge read sees the pre-write contents.
    always_ff @(posedge s_axi_aclk) begin
        if (mem_we) begin
            for (int b = 0; b < int'(StrbW); b++) begin
                if (s_axi_wstrb[b]) begin
                    mem_q[w_idx_q][8*b +: 8] <= s_axi_wdata[8*b +: 8];
                end
            end
        end
    end

    assign s_axi_awready = (w_state_q == WIdle);
    assign s_axi_wready  = (w_state_q == WData);
    assign s_axi_bvalid  = (w_state_q == WResp);
    assign s_axi_bresp   = bresp_q;
    assign s_axi_arready = (r_state_q == RIdle);
    assign s_axi_rvalid  = (r_state_q == RData);
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;
    assign s_axi_rlast   = rlast_q;

endmodule
